// File: rtl/bin_bcd_pkg.sv
// Shared types and sizing helpers for the sequential binary-to-BCD converter.
package bin_bcd_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } st_e;

   // Smallest k with 10^k > 2^w - 1.
   function automatic int bcd_digits(input int w);
      logic [63:0] lim;
      logic [63:0] p;
      int          k;
      lim = (64'd1 << w) - 64'd1;
      p   = 64'd1;
      k   = 0;
      while (p <= lim) begin
         p = p * 64'd10;
         k = k + 1;
      end
      return k;
   endfunction

   function automatic int cnt_w(input int w);
      return $clog2(w);
   endfunction

endpackage

// File: rtl/bin_bcd_adj3.sv
// Double-dabble digit correction: add 3 to any digit of 5 or more.
module bin_bcd_adj3 (
   input  logic [3:0] d,
   output logic [3:0] q
);

   assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/bin_bcd_seq.sv
// Multi-cycle binary-to-BCD converter, one bit per clock,
// optional two's-complement input, valid/ready on both sides.
module bin_bcd_seq
   import bin_bcd_pkg::*;
#(
   parameter int BIN_W  = 8,
   parameter int DIGITS = bcd_digits(BIN_W),
   parameter bit SIGNED = 1'b0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [BIN_W-1:0]    bin_in,
   input  logic                din_vld,
   output logic                din_rdy,
   output logic [4*DIGITS-1:0] bcd_out,
   output logic                sign_out,
   output logic                dout_vld,
   input  logic                dout_rdy
);

   localparam int CNT_W = cnt_w(BIN_W);
   localparam int ACC_W = 4 * DIGITS;

   if (DIGITS < bcd_digits(BIN_W)) begin : g_chk
      $error("DIGITS too small for BIN_W");
   end

   st_e              state;
   st_e              state_nxt;
   logic [BIN_W-1:0] sreg;
   logic [BIN_W-1:0] mag;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] acc_adj;
   logic [ACC_W-1:0] acc_sh;
   logic [CNT_W-1:0] cnt;
   logic             sign_r;
   logic             neg;
   logic             accept;
   logic             last;

   assign neg    = SIGNED && bin_in[BIN_W-1];
   assign mag    = neg ? (~bin_in) + BIN_W'(1) : bin_in;
   assign accept = din_vld && din_rdy;
   assign last   = (cnt == CNT_W'(BIN_W - 1));
   assign acc_sh = {acc_adj[ACC_W-2:0], sreg[BIN_W-1]};

   for (genvar i = 0; i < DIGITS; i++) begin : g_adj
      bin_bcd_adj3 u_adj (
         .d (acc[4*i +: 4]),
         .q (acc_adj[4*i +: 4])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      din_rdy   = 1'b0;
      dout_vld  = 1'b0;
      unique case (state)
         IDLE: begin
            din_rdy = 1'b1;
            if (din_vld) state_nxt = SHIFT;
         end
         SHIFT: begin
            if (last) state_nxt = DONE;
         end
         DONE: begin
            dout_vld = 1'b1;
            if (dout_rdy) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sreg     <= '0;
         acc      <= '0;
         cnt      <= '0;
         sign_r   <= 1'b0;
         bcd_out  <= '0;
         sign_out <= 1'b0;
      end else if (accept) begin
         sreg   <= mag;
         acc    <= '0;
         cnt    <= '0;
         sign_r <= neg;
      end else if (state == SHIFT) begin
         // Rotate rather than shift; the bit wrapped in is always 0.
         acc  <= acc_sh;
         sreg <= {sreg[BIN_W-2:0], acc_adj[ACC_W-1]};
         cnt  <= cnt + CNT_W'(1);
         if (last) begin
            bcd_out  <= acc_sh;
            sign_out <= sign_r;
         end
      end
   end

endmodule

// File: tb/tb_bin_bcd_seq.sv
// Bench for bin_bcd_seq: three configurations against an arithmetic
// reference plus directed literal checks.
module tb_bin_bcd_seq;

   logic        clk;
   logic        rst;
   logic [31:0] bin_v    [3];
   logic        din_vld  [3];
   logic        dout_rdy [3];
   logic        din_rdy  [3];
   logic        dout_vld [3];
   logic        sign_o   [3];
   logic [39:0] bcd_o    [3];
   logic [11:0] bcd0;
   logic [19:0] bcd1;
   logic [11:0] bcd2;

   int compared = 0;
   int mism     = 0;

   int          W [3] = '{8, 16, 8};
   bit          S [3] = '{1'b0, 1'b0, 1'b1};
   int          ph   [3];
   int          left [3];
   logic [39:0] m_bcd [3];
   logic [39:0] p_bcd [3];
   logic        m_sgn [3];
   logic        p_sgn [3];
   bit          model_live;

   assign bcd_o[0] = {28'd0, bcd0};
   assign bcd_o[1] = {20'd0, bcd1};
   assign bcd_o[2] = {28'd0, bcd2};

   bin_bcd_seq #(.BIN_W(8), .SIGNED(1'b0)) u_u8 (
      .clk(clk), .rst(rst), .bin_in(bin_v[0][7:0]),
      .din_vld(din_vld[0]), .din_rdy(din_rdy[0]),
      .bcd_out(bcd0), .sign_out(sign_o[0]),
      .dout_vld(dout_vld[0]), .dout_rdy(dout_rdy[0])
   );

   bin_bcd_seq #(.BIN_W(16), .SIGNED(1'b0)) u_u16 (
      .clk(clk), .rst(rst), .bin_in(bin_v[1][15:0]),
      .din_vld(din_vld[1]), .din_rdy(din_rdy[1]),
      .bcd_out(bcd1), .sign_out(sign_o[1]),
      .dout_vld(dout_vld[1]), .dout_rdy(dout_rdy[1])
   );

   bin_bcd_seq #(.BIN_W(8), .SIGNED(1'b1)) u_s8 (
      .clk(clk), .rst(rst), .bin_in(bin_v[2][7:0]),
      .din_vld(din_vld[2]), .din_rdy(din_rdy[2]),
      .bcd_out(bcd2), .sign_out(sign_o[2]),
      .dout_vld(dout_vld[2]), .dout_rdy(dout_rdy[2])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mism++;
         $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [39:0] to_bcd(input longint unsigned v);
      logic [39:0] r;
      r = '0;
      for (int i = 0; i < 10; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   // Reference: pure arithmetic conversion plus the handshake timeline.
   initial begin
      model_live = 1'b0;
      forever begin
         @(posedge clk);
         for (int k = 0; k < 3; k++) begin
            longint unsigned v;
            longint unsigned full;
            bit              neg;
            if (rst) begin
               ph[k]    = 0;
               m_bcd[k] = '0;
               m_sgn[k] = 1'b0;
            end else begin
               case (ph[k])
                  0: if (din_vld[k]) begin
                     full = longint'(1) << W[k];
                     v    = longint'(bin_v[k]) % full;
                     neg  = S[k] && (v >= full / 2);
                     p_bcd[k] = to_bcd(neg ? full - v : v);
                     p_sgn[k] = neg;
                     left[k]  = W[k];
                     ph[k]    = 1;
                  end
                  1: begin
                     left[k]--;
                     if (left[k] == 0) begin
                        m_bcd[k] = p_bcd[k];
                        m_sgn[k] = p_sgn[k];
                        ph[k]    = 2;
                     end
                  end
                  default: if (dout_rdy[k]) ph[k] = 0;
               endcase
            end
         end
         if (rst) model_live = 1'b1;
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (model_live) begin
            for (int k = 0; k < 3; k++) begin
               chk($sformatf("m%0d_din_rdy", k), din_rdy[k], ph[k] == 0);
               chk($sformatf("m%0d_dout_vld", k), dout_vld[k], ph[k] == 2);
               chk($sformatf("m%0d_bcd", k), bcd_o[k], m_bcd[k]);
               chk($sformatf("m%0d_sign", k), sign_o[k], m_sgn[k]);
            end
         end
      end
   end

   task automatic send(input int k, input logic [31:0] v);
      @(posedge clk); #1;
      bin_v[k]   = v;
      din_vld[k] = 1'b1;
      @(posedge clk); #1;
      din_vld[k] = 1'b0;
   endtask

   task automatic wait_vld(input int k, input int n0, input int lat,
                           input logic [39:0] eb, input logic es,
                           input string nm);
      int n;
      bit got;
      n   = n0;
      got = 1'b0;
      while (!got && n < 100) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (dout_vld[k]) got = 1'b1;
      end
      chk({nm, "_seen"}, got, 1'b1);
      chk({nm, "_lat"}, n, lat);
      chk({nm, "_bcd"}, bcd_o[k], eb);
      chk({nm, "_sign"}, sign_o[k], es);
   endtask

   initial begin
      int nres;
      int last_t;
      bit prev;
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         bin_v[k]    = '0;
         din_vld[k]  = 1'b0;
         dout_rdy[k] = 1'b1;
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk("rst_din_rdy", din_rdy[k], 1'b1);
         chk("rst_dout_vld", dout_vld[k], 1'b0);
         chk("rst_bcd", bcd_o[k], 40'h0);
         chk("rst_sign", sign_o[k], 1'b0);
      end

      send(0, 55);  wait_vld(0, 0, 8, 40'h055, 1'b0, "u8_55");
      send(0, 240); wait_vld(0, 0, 8, 40'h240, 1'b0, "u8_240");
      send(0, 255); wait_vld(0, 0, 8, 40'h255, 1'b0, "u8_255");
      send(0, 0);   wait_vld(0, 0, 8, 40'h000, 1'b0, "u8_0");

      send(1, 65535); wait_vld(1, 0, 16, 40'h65535, 1'b0, "u16_max");
      send(1, 1000);  wait_vld(1, 0, 16, 40'h01000, 1'b0, "u16_1000");

      send(2, 32'h80); wait_vld(2, 0, 8, 40'h128, 1'b1, "s8_80");
      send(2, 32'hFF); wait_vld(2, 0, 8, 40'h001, 1'b1, "s8_ff");
      send(2, 32'h7F); wait_vld(2, 0, 8, 40'h127, 1'b0, "s8_7f");
      send(2, 32'h00); wait_vld(2, 0, 8, 40'h000, 1'b0, "s8_0");

      dout_rdy[0] = 1'b0;
      send(0, 200);
      @(posedge clk); #1;
      bin_v[0]   = 77;
      din_vld[0] = 1'b1;
      @(posedge clk); #1;
      din_vld[0] = 1'b0;
      wait_vld(0, 2, 8, 40'h200, 1'b0, "bp");
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (i == 2) begin
            bin_v[0]   = 33;
            din_vld[0] = 1'b1;
         end
         if (i == 3) din_vld[0] = 1'b0;
         @(negedge clk);
         chk("bp_vld", dout_vld[0], 1'b1);
         chk("bp_bcd", bcd_o[0], 40'h200);
         chk("bp_rdy", din_rdy[0], 1'b0);
      end
      @(posedge clk); #1;
      dout_rdy[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("bp_rel_rdy", din_rdy[0], 1'b1);
      chk("bp_rel_vld", dout_vld[0], 1'b0);
      chk("bp_rel_bcd", bcd_o[0], 40'h200);

      nres   = 0;
      last_t = -1;
      prev   = 1'b0;
      bin_v[0]   = $urandom_range(0, 255);
      din_vld[0] = 1'b1;
      for (int c = 0; c < 70; c++) begin
         @(posedge clk); #1;
         bin_v[0] = $urandom_range(0, 255);
         @(negedge clk);
         if (dout_vld[0] && !prev) begin
            if (last_t >= 0) chk("stream_period", c - last_t, 10);
            last_t = c;
            nres++;
         end
         prev = dout_vld[0];
      end
      din_vld[0] = 1'b0;
      chk("stream_count", nres >= 6, 1'b1);
      repeat (15) @(posedge clk);

      send(0, 150);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_rdy", din_rdy[0], 1'b1);
      chk("mid_rst_vld", dout_vld[0], 1'b0);
      chk("mid_rst_bcd", bcd_o[0], 40'h0);
      repeat (15) begin
         @(negedge clk);
         chk("mid_rst_quiet", dout_vld[0], 1'b0);
      end
      send(0, 99); wait_vld(0, 0, 8, 40'h099, 1'b0, "after_rst");

      repeat (4) @(posedge clk);
      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mism);
      $finish;
   end

endmodule
